// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory slave port between two masters.
// Master 0 is the CPU data port and master 1 is the UART boot loader/DMA path.
// Arbitration is round-robin. When both masters request in the same cycle,
// the one that did not own the bus last wins. Commands are registered on the
// grant edge. The owner gets a single-cycle ack pulse when the slave acks.
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort stalled slave accesses
// after TIMEOUT_CYCLES busy cycles. An aborted access returns all-ones data
// with err set.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_rd,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_rd,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  s_rd,
  output logic                  s_wr,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_ack,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic                  owner;
  logic                  last_owner;
  logic                  m0_req;
  logic                  m1_req;
  logic                  any_req;
  logic                  win;
  logic                  sel_rd;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // The timeout counter is 16 bits wide, so the limit has to fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] busy_cnt;
  logic        timeout_hit;
  assign timeout_hit = (busy_cnt + 16'd1) == TIMEOUT_LIM;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  // Choose the winner. On a tie, the master that was not the last owner wins.
  // The winner's command is then selected for registering.
  always_comb begin
    m0_req  = m0_rd | m0_wr;
    m1_req  = m1_rd | m1_wr;
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) win = ~last_owner;
    else                  win = m1_req;
    sel_rd    = win ? m1_rd    : m0_rd;
    sel_wr    = win ? m1_wr    : m0_wr;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
  end

  // Arbitration FSM: latch the command, wait for the slave, then ack the owner for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      grant      <= 2'b00;
      s_rd       <= 1'b0;
      s_wr       <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      busy_cnt   <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= win;
            last_owner <= win;
            grant      <= win ? 2'b10 : 2'b01;
            s_addr     <= sel_addr;
            s_wdata    <= sel_wdata;
            s_wr       <= sel_wr;
            s_rd       <= sel_rd & ~sel_wr;
            state      <= BUSY;
`ifdef MEM_BUS_TIMEOUT_EN
            busy_cnt   <= 16'd0;
`endif
          end
        end
        BUSY: begin
          if (s_ack) begin
            s_rd  <= 1'b0;
            s_wr  <= 1'b0;
            state <= DONE;
            if (owner) begin
              m1_rdata <= s_rdata;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= s_rdata;
              m0_ack   <= 1'b1;
            end
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (timeout_hit) begin
            s_rd  <= 1'b0;
            s_wr  <= 1'b0;
            state <= DONE;
            if (owner) begin
              m1_rdata <= '1;
              m1_ack   <= 1'b1;
              m1_err   <= 1'b1;
            end else begin
              m0_rdata <= '1;
              m0_ack   <= 1'b1;
              m0_err   <= 1'b1;
            end
          end else begin
            busy_cnt <= busy_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
          m0_err <= 1'b0;
          m1_err <= 1'b0;
`endif
          grant  <= 2'b00;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios with hand-computed expectations.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_rd, m0_wr, m1_rd, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_rd, s_wr, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 unit past it before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
    m0_addr = 0; m0_wdata = 0; m1_addr = 0; m1_wdata = 0;
    s_ack = 0; s_rdata = 0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    #2 reset = 0;
    tick();
    #2 reset = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #12;
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant: got %b want 00", grant); end
    checks++; if ({s_rd, s_wr} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes: got %b want 00", {s_rd, s_wr}); end
    checks++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin errors++; $display("[TB] FAIL reset_acks: got %b want 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    checks++; if ({m0_rdata, m1_rdata, s_addr, s_wdata} !== 128'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", {m0_rdata, m1_rdata, s_addr, s_wdata}); end
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic test_single_read();
    m0_rd = 1; m0_addr = 32'h100;
    tick();
    checks++; if (s_rd !== 1'b1 || s_wr !== 1'b0) begin errors++; $display("[TB] FAIL single_strobe: got rd=%b wr=%b want rd=1 wr=0", s_rd, s_wr); end
    checks++; if (s_addr !== 32'h100) begin errors++; $display("[TB] FAIL single_addr: got %h want 00000100", s_addr); end
    checks++; if (grant !== 2'b01) begin errors++; $display("[TB] FAIL single_grant: got %b want 01", grant); end
    tick();
    checks++; if (m0_ack !== 1'b0 || s_rd !== 1'b1) begin errors++; $display("[TB] FAIL single_wait: got ack=%b s_rd=%b want 0 1", m0_ack, s_rd); end
    s_ack = 1; s_rdata = 32'hDEADBEEF;
    tick();
    s_ack = 0; m0_rd = 0;
    checks++; if (m0_ack !== 1'b1 || s_rd !== 1'b0) begin errors++; $display("[TB] FAIL single_ack: got ack=%b s_rd=%b want 1 0", m0_ack, s_rd); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_rdata: got %h want deadbeef", m0_rdata); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("[TB] FAIL single_m1_ack: got %b want 0", m1_ack); end
    tick();
    checks++; if (m0_ack !== 1'b0 || grant !== 2'b00) begin errors++; $display("[TB] FAIL single_ack_end: got ack=%b grant=%b want 0 00", m0_ack, grant); end
    tick();
    checks++; if (m1_ack !== 1'b0 || grant !== 2'b00) begin errors++; $display("[TB] FAIL single_idle: got m1_ack=%b grant=%b want 0 00", m1_ack, grant); end
  endtask

  task automatic test_tie();
    pulse_reset();
    m0_rd = 1; m0_addr = 32'h10; m1_rd = 1; m1_addr = 32'h20;
    tick();
    checks++; if (grant !== 2'b01 || s_addr !== 32'h10) begin errors++; $display("[TB] FAIL tie_first: got grant=%b addr=%h want 01 00000010", grant, s_addr); end
    s_ack = 1; s_rdata = 32'h1111;
    tick();
    s_ack = 0; m0_rd = 0;
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("[TB] FAIL tie_ack0: got m0=%b m1=%b want 1 0", m0_ack, m1_ack); end
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL tie_gap: got %b want 00", grant); end
    tick();
    checks++; if (grant !== 2'b10 || s_addr !== 32'h20) begin errors++; $display("[TB] FAIL tie_second: got grant=%b addr=%h want 10 00000020", grant, s_addr); end
    s_ack = 1; s_rdata = 32'h1234;
    tick();
    s_ack = 0; m1_rd = 0;
    checks++; if (m1_ack !== 1'b1 || m1_rdata !== 32'h1234 || m0_ack !== 1'b0) begin errors++; $display("[TB] FAIL tie_ack1: got m1_ack=%b rdata=%h m0_ack=%b want 1 00001234 0", m1_ack, m1_rdata, m0_ack); end
    checks++; if (m0_rdata !== 32'h1111) begin errors++; $display("[TB] FAIL tie_m0_hold: got %h want 00001111", m0_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    int acks0;
    int acks1;
    logic [1:0] exp_g;
    acks0 = 0; acks1 = 0;
    pulse_reset();
    m0_rd = 1; m0_addr = 32'hA0; m1_rd = 1; m1_addr = 32'hB0;
    s_ack = 1;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      s_rdata = 32'hC000 + i;
      tick();
      checks++; if (grant !== exp_g) begin errors++; $display("[TB] FAIL b2b_grant%0d: got %b want %b", i, grant, exp_g); end
      checks++; if (s_addr !== ((i % 2 == 0) ? 32'hA0 : 32'hB0)) begin errors++; $display("[TB] FAIL b2b_addr%0d: got %h", i, s_addr); end
      tick();
      acks0 += int'(m0_ack); acks1 += int'(m1_ack);
      checks++; if ({m1_ack, m0_ack} !== exp_g) begin errors++; $display("[TB] FAIL b2b_ack%0d: got %b want %b", i, {m1_ack, m0_ack}, exp_g); end
      checks++; if ((i % 2 == 0 ? m0_rdata : m1_rdata) !== 32'hC000 + i) begin errors++; $display("[TB] FAIL b2b_rdata%0d: got %h want %h", i, (i % 2 == 0 ? m0_rdata : m1_rdata), 32'hC000 + i); end
      tick();
      acks0 += int'(m0_ack); acks1 += int'(m1_ack);
      checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL b2b_gap%0d: got %b want 00", i, grant); end
    end
    checks++; if (acks0 != 3 || acks1 != 3) begin errors++; $display("[TB] FAIL b2b_ack_count: got m0=%0d m1=%0d want 3 3", acks0, acks1); end
    idle_inputs();
    tick();
  endtask

  task automatic test_rd_wr_both();
    m1_rd = 1; m1_wr = 1; m1_addr = 32'h20; m1_wdata = 32'h55;
    tick();
    checks++; if (s_wr !== 1'b1 || s_rd !== 1'b0) begin errors++; $display("[TB] FAIL rdwr_strobe: got rd=%b wr=%b want rd=0 wr=1", s_rd, s_wr); end
    checks++; if (s_wdata !== 32'h55 || s_addr !== 32'h20) begin errors++; $display("[TB] FAIL rdwr_cmd: got wdata=%h addr=%h want 00000055 00000020", s_wdata, s_addr); end
    checks++; if (grant !== 2'b10) begin errors++; $display("[TB] FAIL rdwr_grant: got %b want 10", grant); end
    s_ack = 1;
    tick();
    s_ack = 0; m1_rd = 0; m1_wr = 0;
    checks++; if (m1_ack !== 1'b1 || s_wr !== 1'b0) begin errors++; $display("[TB] FAIL rdwr_ack: got ack=%b s_wr=%b want 1 0", m1_ack, s_wr); end
    tick();
  endtask

  task automatic test_timeout();
    m1_rd = 1; m1_addr = 32'h40;
    tick();
    checks++; if (s_rd !== 1'b1 || grant !== 2'b10) begin errors++; $display("[TB] FAIL to_start: got s_rd=%b grant=%b want 1 10", s_rd, grant); end
    tick(); tick(); tick();
    checks++; if (s_rd !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("[TB] FAIL to_wait: got s_rd=%b ack=%b want 1 0", s_rd, m1_ack); end
    tick();
`ifdef MEM_BUS_TIMEOUT_EN
    m1_rd = 0;
    checks++; if (s_rd !== 1'b0 || m1_ack !== 1'b1 || m1_err !== 1'b1) begin errors++; $display("[TB] FAIL to_fire: got s_rd=%b ack=%b err=%b want 0 1 1", s_rd, m1_ack, m1_err); end
    checks++; if (m1_rdata !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL to_rdata: got %h want ffffffff", m1_rdata); end
    tick();
    checks++; if (m1_ack !== 1'b0 || m1_err !== 1'b0) begin errors++; $display("[TB] FAIL to_clear: got ack=%b err=%b want 0 0", m1_ack, m1_err); end
`else
    tick(); tick();
    checks++; if (s_rd !== 1'b1 || m1_ack !== 1'b0 || m1_err !== 1'b0) begin errors++; $display("[TB] FAIL to_hold: got s_rd=%b ack=%b err=%b want 1 0 0", s_rd, m1_ack, m1_err); end
    s_ack = 1; s_rdata = 32'h77;
    tick();
    s_ack = 0; m1_rd = 0;
    checks++; if (m1_ack !== 1'b1 || m1_rdata !== 32'h77) begin errors++; $display("[TB] FAIL to_late_ack: got ack=%b rdata=%h want 1 00000077", m1_ack, m1_rdata); end
    tick();
`endif
    tick();
  endtask

  task automatic test_async_reset();
    m0_rd = 1; m0_addr = 32'h300;
    tick();
    checks++; if (s_rd !== 1'b1) begin errors++; $display("[TB] FAIL ar_busy: got s_rd=%b want 1", s_rd); end
    #2 reset = 0;
    #1;
    checks++; if (s_rd !== 1'b0 || s_wr !== 1'b0 || grant !== 2'b00) begin errors++; $display("[TB] FAIL ar_drop: got rd=%b wr=%b grant=%b want 0 0 00", s_rd, s_wr, grant); end
    idle_inputs();
    tick();
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("[TB] FAIL ar_no_ack: got %b want 0", m0_ack); end
    #2 reset = 1;
    tick();
    m0_rd = 1; m0_addr = 32'h400; m1_rd = 1; m1_addr = 32'h500;
    tick();
    checks++; if (grant !== 2'b01 || s_addr !== 32'h400) begin errors++; $display("[TB] FAIL ar_tie: got grant=%b addr=%h want 01 00000400", grant, s_addr); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_rd_wr_both();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave arbiter that shares the SoC's single memory port between the CPU data port (master 0) and the UART boot loader/DMA path (master 1). It uses round-robin arbitration with registered commands and a one-cycle ack pulse back to the winning master. It sits between the requesters and the memory inside Risco_5_SOC, in the divided-clock domain driven by the boot reset.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- TIMEOUT_CYCLES, 255, slave-ack timeout in cycles. Used only with MEM_BUS_TIMEOUT_EN. Legal range 1..65535.

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_rd, m0_wr  in  1  master 0 read/write request
- m0_addr  in  ADDR_WIDTH  master 0 address
- m0_wdata  in  DATA_WIDTH  master 0 write data
- m0_rdata  out  DATA_WIDTH  master 0 read data, valid with m0_ack
- m0_ack  out  1  master 0 completion pulse
- m0_err  out  1  master 0 timeout flag, valid with m0_ack
- m1_*  same set as m0_*, for master 1
- s_rd, s_wr  out  1  slave read/write strobe
- s_addr  out  ADDR_WIDTH  slave address
- s_wdata  out  DATA_WIDTH  slave write data
- s_rdata  in  DATA_WIDTH  slave read data, valid with s_ack
- s_ack  in  1  slave completion
- grant  out  2  one-hot current owner; 00 when idle

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values:
  - all outputs 0
  - last_owner = 1, so master 0 wins the first tie
- IDLE:
  - A master is requesting when rd|wr is high.
  - If exactly one master requests, it wins.
  - If both request, the master that is not last_owner wins.
  - On the grant edge, latch owner, addr and wdata, and set last_owner = winner and grant accordingly.
  - Drive s_wr = wr and s_rd = rd & ~wr (write wins if both are high). Go to BUSY.
- BUSY:
  - s_* outputs hold the latched command. Master inputs are ignored.
  - On s_ack:
    - clear s_rd and s_wr
    - capture s_rdata into the owner's rdata register (write: capture too, value unspecified to master)
    - pulse owner's ack for one cycle
    - go to DONE
- DONE:
  - owner's ack = 1 for this single cycle. Requests are ignored.
  - Next cycle: ack = 0, grant = 00, state IDLE.
- Non-owner rdata/ack/err never change during another master's transaction.
- A master holds rd/wr/addr/wdata until it sees ack. It must drop or replace its request in the cycle after ack.
- Async reset at any point:
  - immediately returns to IDLE with all outputs 0 and last_owner = 1
  - an in-flight transaction is abandoned with no ack

## Timing
- Request sampled in IDLE at edge N: s_rd/s_wr and grant high after edge N.
- s_ack high at edge M: s_rd/s_wr low and owner ack high after edge M. Ack low and state IDLE after edge M+1.
- Earliest re-arbitration at edge M+2. Zero-wait slave: 3 cycles per transaction, minimum.
- Back-to-back requests from both masters alternate strictly.

## Configuration
- MEM_BUS_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If the count reaches TIMEOUT_CYCLES with s_ack low: clear s_rd/s_wr, load owner rdata = all-ones, set owner err = 1 with ack, go to DONE.
  - s_ack on the same cycle as the timeout: normal completion wins, err = 0.
  - err clears with ack.
- MEM_BUS_TIMEOUT_EN undefined:
  - no counter
  - m0_err and m1_err are constant 0
  - BUSY waits for s_ack indefinitely

## Test plan
- m0 read addr 0x100, slave acks 2 cycles after s_rd with 0xDEADBEEF -> s_addr=0x100, m0_rdata=0xDEADBEEF, m0_ack pulse exactly 1 cycle, m1_ack stays 0.
- m0 and m1 request in the same cycle right after reset -> m0 served first, then m1. grant sequence 01, 00, 10.
- Both masters request continuously for 6 transactions -> owners alternate 0,1,0,1,0,1. No ack is lost or duplicated.
- m1 asserts rd and wr together, addr 0x20, wdata 0x55 -> s_wr=1, s_rd=0, s_wdata=0x55.
- With MEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks a m1 read -> after 4 BUSY cycles s_rd drops, m1_ack=1, m1_err=1, m1_rdata=0xFFFFFFFF. Without the macro, s_rd stays high.
- reset driven low in BUSY -> s_rd/s_wr/grant drop to 0 without waiting for a clock edge. After release, the next tie goes to m0.
